// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared stage indices and bus FSM encodings
package pipe_hazard_ctrl_pkg;

  // Pipeline stage indices into the stall vector
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef logic [1:0] bus_state_t;

  // Instruction bus FSM; the generic request FSM uses these encodings
  localparam bus_state_t I_IDLE    = 2'd0;
  localparam bus_state_t I_REQ     = 2'd1;
  localparam bus_state_t I_WAIT    = 2'd2;
  localparam bus_state_t I_DISCARD = 2'd3;

  // Data bus FSM; shares values with the I_* states it mirrors
  localparam bus_state_t D_IDLE    = 2'd0;
  localparam bus_state_t D_REQ     = 2'd1;
  localparam bus_state_t D_WAIT    = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_sram_req_fsm.sv
// rtl/pipe_hazard_ctrl_sram_req_fsm.sv - generic req/addr_ok/data_ok bus FSM with discard state
module sram_req_fsm
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       addr_ok,
  input  logic       data_ok,
  output logic       req,
  output bus_state_t state
);

  bus_state_t state_q, state_d;

  // Next state: abort turns an outstanding response into one that is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      I_IDLE:    if (start) state_d = I_REQ;
      I_REQ:     if (addr_ok) state_d = abort ? I_DISCARD : I_WAIT;
      I_WAIT: begin
        if (data_ok)    state_d = I_IDLE;
        else if (abort) state_d = I_DISCARD;
      end
      I_DISCARD: if (data_ok) state_d = I_IDLE;
      default:   state_d = I_IDLE;
    endcase
  end

  // State register; reset returns to idle mid-transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= I_IDLE;
    else      state_q <= state_d;
  end

  // Request is asserted only while the address is being offered
  always_comb begin
    req   = (state_q == I_REQ);
    state = state_q;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with bus and divider tracking
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_load_use,
  input  logic              ex_div_start,
  input  logic              div_done,
  input  logic              mem_req,
  input  logic              exc_valid,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  output logic              inst_req,
  output logic              data_req,
  output logic              inst_buf_we,
  output logic              inst_sel_buf,
  output logic              div_cancel,
  output logic [NSTAGE-1:0] stall,
  output logic              flush
);

  logic              div_busy_q, div_busy_d;
  logic              buf_valid_q, buf_valid_d;
  bus_state_t        i_state, d_state;
  logic              i_req, d_req, i_start, d_start;
  logic              i_data_hit, d_data_hit, buf_we;
  logic              req_if, req_id, req_ex, req_mem;
  logic [NSTAGE-1:0] req_vec, stall_int;
  logic              any_req;

  sram_req_fsm u_inst_fsm (
    .clk     (clk),
    .rst     (rst),
    .start   (i_start),
    .abort   (exc_valid),
    .addr_ok (inst_addr_ok),
    .data_ok (inst_data_ok),
    .req     (i_req),
    .state   (i_state)
  );

  // Data accesses always run to completion, so the discard path is tied off
  sram_req_fsm u_data_fsm (
    .clk     (clk),
    .rst     (rst),
    .start   (d_start),
    .abort   (1'b0),
    .addr_ok (data_addr_ok),
    .data_ok (data_data_ok),
    .req     (d_req),
    .state   (d_state)
  );

  // Per-stage stall requests; IF waits unless an instruction arrives or is buffered
  always_comb begin
    i_data_hit = (i_state == I_WAIT) && inst_data_ok;
    d_data_hit = (d_state == D_WAIT) && data_data_ok;
    req_mem    = mem_req && !d_data_hit;
    req_ex     = ex_div_start || (div_busy_q && !div_done);
    req_id     = id_load_use;
    req_if     = (i_state == I_DISCARD) || (!i_data_hit && !buf_valid_q);
  end

  // Highest requesting stage stalls itself and everything upstream; flush wins
  always_comb begin
    req_vec          = '0;
    req_vec[STG_IF]  = req_if;
    req_vec[STG_ID]  = req_id;
    req_vec[STG_EX]  = req_ex;
    req_vec[STG_MEM] = req_mem;
    req_vec[STG_WB]  = 1'b0;
    any_req          = 1'b0;
    stall_int        = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      any_req      = any_req | req_vec[i];
      stall_int[i] = any_req & ~exc_valid;
    end
  end

  // Bus starts, holding-buffer and divider tracking next state
  always_comb begin
    i_start     = !stall_int[STG_ID] && !buf_valid_q;
    d_start     = mem_req && !exc_valid;
    buf_we      = i_data_hit && stall_int[STG_ID];
    buf_valid_d = buf_valid_q;
    if (buf_we)                               buf_valid_d = 1'b1;
    else if (exc_valid || !stall_int[STG_ID]) buf_valid_d = 1'b0;
    div_busy_d = div_busy_q;
    if (exc_valid)         div_busy_d = 1'b0;
    else if (ex_div_start) div_busy_d = 1'b1;
    else if (div_done)     div_busy_d = 1'b0;
  end

  // Divider-busy and holding-buffer-valid registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_busy_q  <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      div_busy_q  <= div_busy_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Outputs held low during reset, where IF would otherwise request a stall
  always_comb begin
    inst_req     = rst & i_req;
    data_req     = rst & d_req;
    inst_buf_we  = rst & buf_we;
    inst_sel_buf = rst & buf_valid_q;
    div_cancel   = rst & exc_valid & div_busy_q;
    stall        = rst ? stall_int : '0;
    flush        = rst & exc_valid;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_load_use, ex_div_start, div_done, mem_req, exc_valid;
  logic       inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic       inst_req, data_req, inst_buf_we, inst_sel_buf, div_cancel, flush;
  logic [4:0] stall;
  logic [10:0] obs_o, exp_o;

  int total = 0;
  int bad   = 0;

  // reference model: booleans for where each bus transaction stands
  bit m_i_ask, m_i_await, m_i_drop, m_d_ask, m_d_await, m_div, m_buf, m_buf_we;
  logic [4:0] m_stall;

  pipe_hazard_ctrl #(.NSTAGE(5)) dut (
    .clk(clk), .rst(rst), .id_load_use(id_load_use), .ex_div_start(ex_div_start),
    .div_done(div_done), .mem_req(mem_req), .exc_valid(exc_valid),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .inst_req(inst_req), .data_req(data_req), .inst_buf_we(inst_buf_we),
    .inst_sel_buf(inst_sel_buf), .div_cancel(div_cancel), .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  assign obs_o = {inst_req, data_req, inst_buf_we, inst_sel_buf, div_cancel, stall, flush};

  task automatic clear_inputs();
    id_load_use = 0; ex_div_start = 0; div_done = 0; mem_req = 0; exc_valid = 0;
    inst_addr_ok = 0; inst_data_ok = 0; data_addr_ok = 0; data_data_ok = 0;
  endtask

  task automatic model_reset();
    m_i_ask = 0; m_i_await = 0; m_i_drop = 0; m_d_ask = 0; m_d_await = 0;
    m_div = 0; m_buf = 0; m_buf_we = 0; m_stall = '0;
  endtask

  // let inputs settle, then derive the expected outputs from the stall rules
  task automatic model_eval();
    logic [3:0] src;
    int top;
    bit i_got, d_got;
    #2;
    i_got  = m_i_await && inst_data_ok;
    d_got  = m_d_await && data_data_ok;
    src[3] = mem_req && !d_got;
    src[2] = ex_div_start || (m_div && !div_done);
    src[1] = id_load_use;
    src[0] = m_i_drop || (!i_got && !m_buf);
    top = -1;
    for (int k = 0; k < 4; k++) if (src[k]) top = k;
    if (exc_valid || top < 0) m_stall = 5'd0;
    else m_stall = 5'((1 << (top + 1)) - 1);
    m_buf_we = i_got && m_stall[1];
    exp_o = {m_i_ask, m_d_ask, m_buf_we, m_buf, exc_valid && m_div, m_stall, exc_valid};
  endtask

  // advance the model over the coming clock edge, then move to just after it
  task automatic step_clk();
    if (m_i_drop) begin
      if (inst_data_ok) m_i_drop = 0;
    end else if (m_i_await) begin
      if (inst_data_ok) m_i_await = 0;
      else if (exc_valid) begin m_i_await = 0; m_i_drop = 1; end
    end else if (m_i_ask) begin
      if (inst_addr_ok) begin
        m_i_ask = 0;
        if (exc_valid) m_i_drop = 1; else m_i_await = 1;
      end
    end else if (!m_stall[1] && !m_buf) m_i_ask = 1;
    if (m_buf_we) m_buf = 1;
    else if (exc_valid || !m_stall[1]) m_buf = 0;
    if (exc_valid) m_div = 0;
    else if (ex_div_start) m_div = 1;
    else if (div_done) m_div = 0;
    if (m_d_await) begin
      if (data_data_ok) m_d_await = 0;
    end else if (m_d_ask) begin
      if (data_addr_ok) begin m_d_ask = 0; m_d_await = 1; end
    end else if (mem_req && !exc_valid) m_d_ask = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic reach_i_wait();
    int n = 0;
    clear_inputs();
    while (!m_i_await && n < 12) begin
      inst_addr_ok = m_i_ask;
      inst_data_ok = m_i_drop;
      model_eval();
      step_clk();
      n++;
    end
    clear_inputs();
    if (!m_i_await) begin
      total++; bad++;
      $display("FAIL reach_i_wait: fetch not outstanding after %0d cycles, want outstanding", n);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    mem_req = 1; exc_valid = 1; id_load_use = 1; inst_data_ok = 1;
    #12;
    total++;
    if (obs_o !== 11'd0) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs_o, 11'd0); end
    @(posedge clk); #1;
    total++;
    if (obs_o !== 11'd0) begin bad++; $display("FAIL reset_hold: got %b want %b", obs_o, 11'd0); end
    clear_inputs();
    rst = 1;
    model_reset();
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_load_use = 1;
    model_eval();
    total += 2;
    if (obs_o !== exp_o) begin bad++; $display("FAIL load_use_model: got %b want %b", obs_o, exp_o); end
    if (stall !== 5'b00011) begin bad++; $display("FAIL load_use_stall: got %b want %b", stall, 5'b00011); end
    step_clk();
    id_load_use = 0;
    model_eval();
    total += 2;
    if (obs_o !== exp_o) begin bad++; $display("FAIL load_use_after: got %b want %b", obs_o, exp_o); end
    if (stall[4:1] !== 4'b0000) begin bad++; $display("FAIL load_use_release: got %b want %b", stall[4:1], 4'b0000); end
    step_clk();
  endtask

  task automatic test_div();
    clear_inputs();
    for (int c = 0; c <= 32; c++) begin
      ex_div_start = (c == 0);
      div_done     = (c == 32);
      model_eval();
      total += 2;
      if (obs_o !== exp_o) begin bad++; $display("FAIL div_model c=%0d: got %b want %b", c, obs_o, exp_o); end
      if (stall[4:1] !== ((c < 32) ? 4'b0011 : 4'b0000)) begin
        bad++; $display("FAIL div_stall c=%0d: got %b want %b", c, stall[4:1], (c < 32) ? 4'b0011 : 4'b0000);
      end
      step_clk();
    end
    clear_inputs();
  endtask

  task automatic test_data_wait();
    clear_inputs();
    for (int c = 0; c <= 6; c++) begin
      mem_req      = (c <= 5);
      data_addr_ok = (c == 2);
      data_data_ok = (c == 5);
      model_eval();
      total += 3;
      if (obs_o !== exp_o) begin bad++; $display("FAIL data_model c=%0d: got %b want %b", c, obs_o, exp_o); end
      if (data_req !== (c == 1 || c == 2)) begin bad++; $display("FAIL data_req c=%0d: got %b want %b", c, data_req, (c == 1 || c == 2)); end
      if (stall[3] !== (c < 5)) begin bad++; $display("FAIL data_stall c=%0d: got %b want %b", c, stall[3], (c < 5)); end
      step_clk();
    end
    clear_inputs();
  endtask

  task automatic test_flush_wait();
    reach_i_wait();
    for (int c = 0; c <= 5; c++) begin
      exc_valid    = (c == 0);
      inst_data_ok = (c == 3);
      model_eval();
      total++;
      if (obs_o !== exp_o) begin bad++; $display("FAIL flush_model c=%0d: got %b want %b", c, obs_o, exp_o); end
      if (c == 0) begin
        total++;
        if ({flush, stall} !== 6'b100000) begin bad++; $display("FAIL flush_now: got %b want %b", {flush, stall}, 6'b100000); end
      end
      if (c == 3) begin
        total++;
        if ({inst_buf_we, stall[0]} !== 2'b01) begin bad++; $display("FAIL flush_drop: got %b want %b", {inst_buf_we, stall[0]}, 2'b01); end
      end
      if (c >= 4) begin
        total++;
        if (inst_req !== (c == 5)) begin bad++; $display("FAIL flush_refetch c=%0d: got %b want %b", c, inst_req, (c == 5)); end
      end
      step_clk();
    end
    clear_inputs();
  endtask

  task automatic test_fetch_stall();
    reach_i_wait();
    for (int c = 0; c <= 4; c++) begin
      id_load_use  = (c <= 2);
      inst_data_ok = (c == 0);
      model_eval();
      total += 2;
      if (obs_o !== exp_o) begin bad++; $display("FAIL fetch_model c=%0d: got %b want %b", c, obs_o, exp_o); end
      if ({inst_buf_we, inst_sel_buf, inst_req} !== {c == 0, c >= 1 && c <= 3, 1'b0}) begin
        bad++;
        $display("FAIL fetch_buf c=%0d: got %b want %b", c, {inst_buf_we, inst_sel_buf, inst_req}, {c == 0, c >= 1 && c <= 3, 1'b0});
      end
      step_clk();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    int n = 0;
    clear_inputs();
    mem_req = 1;
    while (!m_d_await && n < 8) begin
      data_addr_ok = m_d_ask;
      model_eval();
      step_clk();
      n++;
    end
    data_addr_ok = 0;
    if (!m_d_await) begin total++; bad++; $display("FAIL areset_setup: data access not outstanding after %0d cycles", n); end
    #2;
    rst = 0;
    #1;
    total++;
    if (obs_o !== 11'd0) begin bad++; $display("FAIL areset_immediate: got %b want %b", obs_o, 11'd0); end
    model_reset();
    clear_inputs();
    @(posedge clk); #1;
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      data_data_ok = (c == 0);
      model_eval();
      total += 2;
      if (obs_o !== exp_o) begin bad++; $display("FAIL areset_model c=%0d: got %b want %b", c, obs_o, exp_o); end
      if ({data_req, stall[3]} !== 2'b00) begin bad++; $display("FAIL areset_ignore c=%0d: got %b want %b", c, {data_req, stall[3]}, 2'b00); end
      step_clk();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      exc_valid    = ($urandom_range(99) < 4);
      mem_req      = !exc_valid && ($urandom_range(99) < 35);
      id_load_use  = ($urandom_range(99) < 15);
      ex_div_start = ($urandom_range(99) < 5);
      div_done     = ($urandom_range(99) < 10);
      inst_addr_ok = ($urandom_range(99) < 50);
      inst_data_ok = ($urandom_range(99) < 40);
      data_addr_ok = ($urandom_range(99) < 50);
      data_data_ok = ($urandom_range(99) < 40);
      model_eval();
      total++;
      if (obs_o !== exp_o) begin bad++; $display("FAIL random c=%0d: got %b want %b", c, obs_o, exp_o); end
      step_clk();
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_div();
    test_data_wait();
    test_flush_wait();
    test_fetch_stall();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
